// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray width, debounce FSM states and single-bit step helper.
package gray_pkg;
  localparam int GRAY_W = 4;
  typedef enum logic {IDLE, COUNT} state_t;
  function automatic logic gray_step_ok(input logic [GRAY_W-1:0] a, input logic [GRAY_W-1:0] b);
    return $countones(a ^ b) == 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, cleared to zero on asynchronous reset.
module sync_2ff #(parameter int W = 1) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/gray_input_conditioner.sv
// gray_input_conditioner: synchronizes and debounces a raw Gray code, pulsing valid on each accepted change.
// Define GRAY_STEP_CHECK_EN to build the sticky step_err flag for multi-bit steps.
module gray_input_conditioner
  import gray_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRAY_W-1:0] INgray_raw,
  input  logic              clr_err,
  output logic [GRAY_W-1:0] OUTgray,
  output logic              valid,
  output logic              step_err
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  logic [GRAY_W-1:0] sync2, cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  state_t state, state_n;
  logic commit;
  sync_2ff #(.W(GRAY_W)) u_sync (.clk(clk), .reset(reset), .d(INgray_raw), .q(sync2));
  always_comb begin
    state_n = state;
    cand_n = cand;
    cnt_n = cnt;
    commit = 1'b0;
    if (state == IDLE) begin
      if (sync2 != OUTgray) begin
        cand_n = sync2;
        cnt_n = CW'(1);
        state_n = COUNT;
      end
    end else if (sync2 == OUTgray) begin
      cnt_n = '0;
      state_n = IDLE;
    end else if (sync2 != cand) begin
      cand_n = sync2;
      cnt_n = CW'(1);
    end else if (cnt == CNT_MAX) begin
      commit = 1'b1;
      cnt_n = '0;
      state_n = IDLE;
    end else cnt_n = cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cand <= '0;
      cnt <= '0;
      OUTgray <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      cand <= cand_n;
      cnt <= cnt_n;
      valid <= commit;
      if (commit) OUTgray <= cand;
    end
`ifdef GRAY_STEP_CHECK_EN
  // a new error in the same cycle as clr_err keeps the flag set
  always_ff @(posedge clk or posedge reset)
    if (reset) step_err <= 1'b0;
    else if (commit && !gray_step_ok(cand, OUTgray)) step_err <= 1'b1;
    else if (clr_err) step_err <= 1'b0;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign step_err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_input_conditioner.sv
// tb_gray_input_conditioner: directed and random checks against a sample-history reference model.
module tb_gray_input_conditioner;
  localparam int D = 4;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, clr_err = 1'b0, valid, step_err;
  logic [3:0] raw = 4'd0, outg;
  int checks = 0, fails = 0, nv;
  gray_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .INgray_raw(raw), .clr_err(clr_err),
    .OUTgray(outg), .valid(valid), .step_err(step_err)
  );
  always #5 clk = ~clk;
  // Model: a code is accepted once D+1 consecutive synchronized samples agree and differ from the output.
  logic [3:0] m_s1, m_s2, m_out;
  logic m_valid, m_err;
  logic [3:0] hist[$];
  always @(posedge clk or posedge reset) begin
    logic [3:0] s;
    bit stable;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_out = 0; m_valid = 0; m_err = 0;
      hist.delete();
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      hist.push_back(s);
      if (hist.size() > D + 1) void'(hist.pop_front());
      stable = (hist.size() == D + 1) && (s != m_out);
      foreach (hist[i]) if (hist[i] != s) stable = 0;
      if (ERR_EN && stable && $countones(s ^ m_out) != 1) m_err = 1;
      else if (ERR_EN && clr_err) m_err = 0;
      m_valid = stable;
      if (stable) m_out = s;
    end
  end
  task automatic test_reset();
    reset = 1; raw = 0; clr_err = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({outg, valid, step_err} !== 6'b0) begin
      fails++; $display("FAIL reset_values got %b want 000000", {outg, valid, step_err});
    end
    reset = 0; nv = 0;
    repeat (20) begin
      @(negedge clk); nv += int'(valid);
      checks++;
      if ({outg, valid, step_err} !== {m_out, m_valid, m_err}) begin
        fails++; $display("FAIL reset_idle out/valid/err=%b/%b/%b want %b/%b/%b", outg, valid, step_err, m_out, m_valid, m_err);
      end
    end
    checks++;
    if (nv !== 0) begin fails++; $display("FAIL reset_idle_valids got %0d want 0", nv); end
  endtask
  task automatic test_step();
    int dut_lat = -1, mod_lat = -1;
    raw = 4'b0001; nv = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); nv += int'(valid);
      if (valid && dut_lat < 0) dut_lat = k;
      if (m_valid && mod_lat < 0) mod_lat = k;
      checks++;
      if ({outg, valid, step_err} !== {m_out, m_valid, m_err}) begin
        fails++; $display("FAIL step out/valid/err=%b/%b/%b want %b/%b/%b", outg, valid, step_err, m_out, m_valid, m_err);
      end
    end
    checks++;
    if (dut_lat !== mod_lat || dut_lat < 0) begin fails++; $display("FAIL step_latency got %0d want %0d", dut_lat, mod_lat); end
    checks++;
    if (nv !== 1 || outg !== 4'b0001 || step_err !== 1'b0) begin
      fails++; $display("FAIL step_final valids=%0d out=%b err=%b want 1/0001/0", nv, outg, step_err);
    end
  endtask
  task automatic test_glitch();
    raw = 4'b0011; nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); nv += int'(valid);
      if (k == 2) raw = 4'b0001;
      checks++;
      if ({outg, valid, step_err} !== {m_out, m_valid, m_err}) begin
        fails++; $display("FAIL glitch out/valid/err=%b/%b/%b want %b/%b/%b", outg, valid, step_err, m_out, m_valid, m_err);
      end
    end
    checks++;
    if (nv !== 0 || outg !== 4'b0001) begin fails++; $display("FAIL glitch_final valids=%0d out=%b want 0/0001", nv, outg); end
  endtask
  task automatic test_bad_step();
    raw = 4'b0110; nv = 0;
    repeat (15) begin
      @(negedge clk); nv += int'(valid);
      checks++;
      if ({outg, valid, step_err} !== {m_out, m_valid, m_err}) begin
        fails++; $display("FAIL bad_step out/valid/err=%b/%b/%b want %b/%b/%b", outg, valid, step_err, m_out, m_valid, m_err);
      end
    end
    checks++;
    if (nv !== 1 || outg !== 4'b0110 || step_err !== ERR_EN) begin
      fails++; $display("FAIL bad_step_final valids=%0d out=%b err=%b want 1/0110/%b", nv, outg, step_err, ERR_EN);
    end
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    checks++;
    if (step_err !== 1'b0 || m_err !== 1'b0) begin fails++; $display("FAIL clr_err got %b want 0", step_err); end
  endtask
  task automatic test_restart();
    raw = 4'b0111; nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); nv += int'(valid);
      if (k == 1) raw = 4'b0101;
      checks++;
      if ({outg, valid, step_err} !== {m_out, m_valid, m_err}) begin
        fails++; $display("FAIL restart out/valid/err=%b/%b/%b want %b/%b/%b", outg, valid, step_err, m_out, m_valid, m_err);
      end
    end
    checks++;
    if (nv !== 1 || outg !== 4'b0101) begin fails++; $display("FAIL restart_final valids=%0d out=%b want 1/0101", nv, outg); end
  endtask
  task automatic test_reset_mid();
    raw = 4'b0100;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({outg, valid, step_err} !== 6'b0) begin
      fails++; $display("FAIL reset_mid_values got %b want 000000", {outg, valid, step_err});
    end
    @(negedge clk);
    reset = 0; nv = 0;
    repeat (20) begin
      @(negedge clk); nv += int'(valid);
      checks++;
      if ({outg, valid, step_err} !== {m_out, m_valid, m_err}) begin
        fails++; $display("FAIL reset_mid out/valid/err=%b/%b/%b want %b/%b/%b", outg, valid, step_err, m_out, m_valid, m_err);
      end
    end
    checks++;
    if (nv !== 1 || outg !== 4'b0100) begin fails++; $display("FAIL reset_mid_final valids=%0d out=%b want 1/0100", nv, outg); end
  endtask
  task automatic test_random();
    repeat (120) begin
      raw = $urandom_range(0, 1) ? raw ^ (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      clr_err = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(1, 2 * D + 3)) begin
        @(negedge clk);
        clr_err = 0;
        checks++;
        if ({outg, valid, step_err} !== {m_out, m_valid, m_err}) begin
          fails++; $display("FAIL random out/valid/err=%b/%b/%b want %b/%b/%b", outg, valid, step_err, m_out, m_valid, m_err);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_bad_step();
    test_restart();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
